mips_state_dumper: RTL and testbench

//  Streams a snapshot of the MIPS register bank and data memory out as bytes to the UART TX FIFO.

---
 rtl/mips_state_dumper_pkg.sv | 30 +++
 rtl/mips_state_dumper_if.sv | 27 ++
 rtl/mips_state_dumper.sv | 137 +++++++++++++
 tb/tb_mips_state_dumper.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_state_dumper_pkg.sv
// Shared debugger definitions: default bus sizes, dumper state encoding and the
// byte-stream ordering agreed between the debugger hardware and the host script.
package mips_state_dumper_pkg;

  localparam int unsigned DEF_UART_BUS_SIZE          = 8;
  localparam int unsigned DEF_REGISTER_SIZE          = 32;
  localparam int unsigned DEF_REGISTER_BANK_BUS_SIZE = 1024;
  localparam int unsigned DEF_MEMORY_DATA_BUS_SIZE   = 1024;

  typedef logic [1:0] dump_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Stream order: every word MSB byte first, register bank before data memory.
  localparam bit MSB_BYTE_FIRST  = 1'b1;
  localparam bit REGS_BEFORE_MEM = 1'b1;

  function automatic int unsigned bytes_per_word(input int unsigned reg_size,
                                                 input int unsigned uart_size);
    return reg_size / uart_size;
  endfunction

  // Index width that stays legal for single-entry ranges.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/mips_state_dumper_if.sv
// Debugger-to-dumper bus: start/flow-control inputs, snapshot sources and UART write port.
interface mips_state_dumper_if #(
  parameter int unsigned REG_BANK_W = 1024,
  parameter int unsigned MEM_W      = 1024,
  parameter int unsigned UART_W     = 8
);

  logic                  i_start;
  logic                  i_uart_full;
  logic [REG_BANK_W-1:0] i_registers_conntent;
  logic [MEM_W-1:0]      i_memory_conntent;
  logic                  o_uart_wr;
  logic [UART_W-1:0]     o_uart_data_wr;
  logic                  o_busy;
  logic                  o_done;

  modport slave (
    input  i_start, i_uart_full, i_registers_conntent, i_memory_conntent,
    output o_uart_wr, o_uart_data_wr, o_busy, o_done
  );

  modport master (
    output i_start, i_uart_full, i_registers_conntent, i_memory_conntent,
    input  o_uart_wr, o_uart_data_wr, o_busy, o_done
  );

endinterface

// File: rtl/mips_state_dumper.sv
// Snapshots the MIPS register bank and data memory on start and streams the
// snapshot byte by byte into the UART TX FIFO, honouring FIFO-full backpressure.
module mips_state_dumper
  import mips_state_dumper_pkg::*;
#(
  parameter int unsigned UART_BUS_SIZE          = DEF_UART_BUS_SIZE,
  parameter int unsigned REGISTER_SIZE          = DEF_REGISTER_SIZE,
  parameter int unsigned REGISTER_BANK_BUS_SIZE = DEF_REGISTER_BANK_BUS_SIZE,
  parameter int unsigned MEMORY_DATA_BUS_SIZE   = DEF_MEMORY_DATA_BUS_SIZE
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  mips_state_dumper_if.slave    bus
);

  localparam int unsigned BPW    = bytes_per_word(REGISTER_SIZE, UART_BUS_SIZE);
  localparam int unsigned NREG   = REGISTER_BANK_BUS_SIZE / REGISTER_SIZE;
  localparam int unsigned NMEM   = MEMORY_DATA_BUS_SIZE / REGISTER_SIZE;
  localparam int unsigned NWORDS = NREG + NMEM;
  localparam int unsigned TOTAL  = NWORDS * BPW;
  localparam int unsigned CNT_W  = $clog2(TOTAL + 1);
  localparam int unsigned WIDX_W = clog2_min1(NWORDS);
  localparam int unsigned BIDX_W = clog2_min1(BPW);

  typedef logic [BPW-1:0][UART_BUS_SIZE-1:0] word_bytes_t;

  dump_state_t                       state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [REGISTER_BANK_BUS_SIZE-1:0] reg_snap_q;
  logic [MEMORY_DATA_BUS_SIZE-1:0]   mem_snap_q;
  logic                              busy_q, done_q;
  logic                              load_c, wr_c;

  logic [REGISTER_SIZE-1:0]          words [NWORDS];
  logic [WIDX_W-1:0]                 word_idx;
  logic [BIDX_W-1:0]                 byte_in_word;
  logic [BIDX_W-1:0]                 lane;
  word_bytes_t                       cur_word;
  logic [UART_BUS_SIZE-1:0]          cur_byte;

  // State and byte counter
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; the write strobe follows FIFO space combinationally
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_c  = 1'b0;
    wr_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          load_c  = 1'b1;
          cnt_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        wr_c = !bus.i_uart_full;
        if (wr_c) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(TOTAL - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Snapshot of both content buses, frozen for the whole dump
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      reg_snap_q <= '0;
      mem_snap_q <= '0;
    end else if (load_c) begin
      reg_snap_q <= bus.i_registers_conntent;
      mem_snap_q <= bus.i_memory_conntent;
    end
  end

  // Status flags, registered from the next state
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d == ST_SEND);
      done_q <= (state_d == ST_DONE);
    end
  end

  // Flat word view of the snapshot in stream order
  for (genvar g = 0; g < NREG; g++) begin : g_reg_words
    if (REGS_BEFORE_MEM) begin : g_first
      assign words[g] = reg_snap_q[g*REGISTER_SIZE +: REGISTER_SIZE];
    end else begin : g_second
      assign words[NMEM+g] = reg_snap_q[g*REGISTER_SIZE +: REGISTER_SIZE];
    end
  end

  for (genvar g = 0; g < NMEM; g++) begin : g_mem_words
    if (REGS_BEFORE_MEM) begin : g_second
      assign words[NREG+g] = mem_snap_q[g*REGISTER_SIZE +: REGISTER_SIZE];
    end else begin : g_first
      assign words[g] = mem_snap_q[g*REGISTER_SIZE +: REGISTER_SIZE];
    end
  end

  // Byte selection; idle counter value TOTAL truncates to a harmless in-range index
  always_comb begin
    word_idx     = WIDX_W'(cnt_q / CNT_W'(BPW));
    byte_in_word = BIDX_W'(cnt_q % CNT_W'(BPW));
    lane         = MSB_BYTE_FIRST ? (BIDX_W'(BPW - 1) - byte_in_word) : byte_in_word;
    cur_word     = words[word_idx];
    cur_byte     = cur_word[lane];
  end

  assign bus.o_uart_wr      = wr_c;
  assign bus.o_uart_data_wr = (state_q == ST_SEND) ? cur_byte : '0;
  assign bus.o_busy         = busy_q;
  assign bus.o_done         = done_q;

endmodule

// File: tb/tb_mips_state_dumper.sv
// Self-checking bench for mips_state_dumper: directed scenarios plus random data and
// backpressure, compared against a byte-stream model built from the word arrays.
module tb_mips_state_dumper;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_state_dumper_if #(.REG_BANK_W(1024), .MEM_W(1024), .UART_W(8)) bus ();

  mips_state_dumper dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int         idx;
    logic [7:0] exp;
  } vec_t;

  logic [31:0] r_words [32];
  logic [31:0] m_words [32];
  logic [7:0]  expq [$];
  logic [7:0]  cap  [$];
  int          done_cnt;
  int          done_d;
  int          first_wr_d;
  int          wr_full_cnt;
  int          d;
  int          passed;
  int          total;
  vec_t        tbl [8];

  // Monitor sampled mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (bus.o_uart_wr) begin
      cap.push_back(bus.o_uart_data_wr);
      if (first_wr_d < 0) first_wr_d <= d;
      if (bus.i_uart_full) wr_full_cnt <= wr_full_cnt + 1;
    end
    if (bus.o_done) begin
      done_cnt <= done_cnt + 1;
      done_d   <= d;
    end
  end

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic drive_buses();
    for (int k = 0; k < 32; k++) begin
      bus.i_registers_conntent[k*32 +: 32] = r_words[k];
      bus.i_memory_conntent[k*32 +: 32]    = m_words[k];
    end
  endtask

  // Reference stream: registers then memory, each word most significant byte first
  task automatic build_expected();
    logic [31:0] w;
    expq.delete();
    for (int i = 0; i < 64; i++) begin
      w = (i < 32) ? r_words[i] : m_words[i-32];
      for (int b = 0; b < 4; b++) expq.push_back(w[(3-b)*8 +: 8]);
    end
  endtask

  function automatic logic full_fn(input int mode, input int dc);
    case (mode)
      1:       return (dc >= 10 && dc <= 19);
      2:       return (dc % 2 == 1);
      3:       return ($urandom_range(0, 2) == 0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_stream(input string name);
    int mism;
    mism = 0;
    check({name, "_len"}, cap.size(), expq.size());
    for (int i = 0; i < cap.size() && i < expq.size(); i++)
      if (cap[i] !== expq[i]) mism++;
    check({name, "_bytes"}, mism, 0);
    check({name, "_wr_while_full"}, wr_full_cnt, 0);
  endtask

  // Runs one dump from the current posedge+1 point; mode selects the FIFO-full pattern
  task automatic run_dump(input int mode, input int pulse_at, input bit zero_bus,
                          input int reset_at, output bit aborted);
    int  n;
    bit  pulsed;
    aborted     = 1'b0;
    pulsed      = 1'b0;
    cap.delete();
    done_cnt    = 0;
    done_d      = -1;
    first_wr_d  = -1;
    wr_full_cnt = 0;
    d           = -1;
    bus.i_start     = 1'b1;
    bus.i_uart_full = 1'b0;
    @(posedge clk); #1;
    bus.i_start     = 1'b0;
    d               = 0;
    bus.i_uart_full = full_fn(mode, 0);
    if (zero_bus) begin
      bus.i_registers_conntent = '0;
      bus.i_memory_conntent    = '0;
    end
    check("busy_after_start", bus.o_busy, 1);
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(posedge clk); #1;
      d++;
      n++;
      bus.i_uart_full = full_fn(mode, d);
      bus.i_start     = 1'b0;
      if (pulse_at >= 0 && !pulsed && cap.size() == pulse_at) begin
        bus.i_start = 1'b1;
        pulsed      = 1'b1;
      end
      if (reset_at >= 0 && cap.size() == reset_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_wr", bus.o_uart_wr, 0);
        check("abort_busy", bus.o_busy, 0);
        check("abort_data", bus.o_uart_data_wr, 0);
        @(posedge clk); #1;
        rst_n           = 1'b1;
        bus.i_uart_full = 1'b0;
        aborted         = 1'b1;
        return;
      end
    end
    check("done_seen", (done_cnt > 0), 1);
    bus.i_start     = 1'b0;
    bus.i_uart_full = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      d++;
    end
    check("done_count", done_cnt, 1);
    check("idle_after_done", bus.o_busy, 0);
  endtask

  initial begin
    bit ab;
    passed = 0;
    total  = 0;
    tbl[0] = '{0,   8'hA0};
    tbl[1] = '{1,   8'hB0};
    tbl[2] = '{2,   8'hC0};
    tbl[3] = '{3,   8'h00};
    tbl[4] = '{4,   8'hA0};
    tbl[5] = '{7,   8'h01};
    tbl[6] = '{128, 8'hD0};
    tbl[7] = '{255, 8'h1F};

    for (int i = 0; i < 32; i++) begin
      r_words[i] = 32'hA0B0C000 + 32'(i);
      m_words[i] = 32'hD0000000 + 32'(i);
    end
    bus.i_start     = 1'b0;
    bus.i_uart_full = 1'b0;
    drive_buses();
    d = -1;
    done_cnt = 0;
    first_wr_d = -1;
    wr_full_cnt = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_wr", bus.o_uart_wr, 0);
    check("rst_data", bus.o_uart_data_wr, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_done", bus.o_done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: unthrottled dump with the reference pattern
    build_expected();
    run_dump(0, -1, 1'b0, -1, ab);
    check_stream("t1");
    check("t1_first_wr_cycle", first_wr_d, 0);
    check("t1_done_cycle", done_d, 256);
    for (int i = 0; i < 8; i++)
      check($sformatf("t1_byte%0d", tbl[i].idx),
            (cap.size() > tbl[i].idx) ? longint'(cap[tbl[i].idx]) : 64'hFFFF, tbl[i].exp);

    // 2: FIFO full for dump cycles 10..19
    run_dump(1, -1, 1'b0, -1, ab);
    check_stream("t2");
    check("t2_done_cycle", done_d, 266);

    // 3: buses cleared one cycle after start
    run_dump(0, -1, 1'b1, -1, ab);
    check_stream("t3");
    drive_buses();

    // 4: second start mid-dump is ignored
    run_dump(0, 50, 1'b0, -1, ab);
    check_stream("t4");
    check("t4_done_cycle", done_d, 256);

    // 5: reset at byte 100, then a fresh complete dump
    run_dump(0, -1, 1'b0, 100, ab);
    check("t5_aborted", ab, 1);
    check("t5_partial_len", cap.size(), 100);
    run_dump(0, -1, 1'b0, -1, ab);
    check_stream("t5");
    check("t5_first_byte", (cap.size() > 0) ? longint'(cap[0]) : 64'hFFFF, 8'hA0);

    // 6: FIFO full toggling every cycle
    run_dump(2, -1, 1'b0, -1, ab);
    check_stream("t6");
    check("t6_done_cycle", done_d, 511);

    // Random contents with random backpressure
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 32; i++) begin
        r_words[i] = $urandom();
        m_words[i] = $urandom();
      end
      drive_buses();
      build_expected();
      run_dump(3, -1, 1'b0, -1, ab);
      check_stream($sformatf("rnd%0d", it));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
